// File: rtl/ex_maddsub_unit_pkg.sv
// Shared definitions for the EX-stage multiply-accumulate unit:
// opcodes, stall polarity, reset level, bus types and FSM state encodings.
package ex_maddsub_unit_pkg;

   typedef logic [31:0] RegBus;
   typedef logic [63:0] DoubleRegBus;

   localparam logic [7:0] EXE_MADD_OP  = 8'b10100110;
   localparam logic [7:0] EXE_MADDU_OP = 8'b10100111;
   localparam logic [7:0] EXE_MSUB_OP  = 8'b10101010;
   localparam logic [7:0] EXE_MSUBU_OP = 8'b10101011;

   localparam logic  STOP      = 1'b1;
   localparam logic  NOSTOP    = 1'b0;
   localparam logic  RstEnable = 1'b0;
   localparam RegBus ZeroWord  = 32'h0000_0000;

   localparam int StallExBit = 3;

   typedef enum logic [1:0] {
      MADD_IDLE = 2'd0,
      MADD_MUL2 = 2'd1,
      MADD_ACC  = 2'd2
   } maddState_e;

   function automatic logic isMaddFamily(input logic [7:0] op);
      return op inside {EXE_MADD_OP, EXE_MADDU_OP, EXE_MSUB_OP, EXE_MSUBU_OP};
   endfunction

   function automatic logic isMaddSigned(input logic [7:0] op);
      return op inside {EXE_MADD_OP, EXE_MSUB_OP};
   endfunction

   function automatic logic isMaddSub(input logic [7:0] op);
      return op inside {EXE_MSUB_OP, EXE_MSUBU_OP};
   endfunction

endpackage

// File: rtl/ex_maddsub_unit_if.sv
// Bundle of the ID/EX inputs, forwarded HI/LO and the result/stall outputs
// of the multiply-accumulate unit. The pipeline drives it as master.
interface ex_maddsub_unit_if;
   import ex_maddsub_unit_pkg::*;

   logic [5:0] stall;
   logic [7:0] aluop_i;
   RegBus      reg1_i;
   RegBus      reg2_i;
   RegBus      hi_i;
   RegBus      lo_i;
   logic       stallreq_o;
   logic       hilo_we_o;
   RegBus      hi_o;
   RegBus      lo_o;
   logic       busy_o;

   modport master (
      output stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
      input  stallreq_o, hilo_we_o, hi_o, lo_o, busy_o
   );

   modport slave (
      input  stall, aluop_i, reg1_i, reg2_i, hi_i, lo_i,
      output stallreq_o, hilo_we_o, hi_o, lo_o, busy_o
   );

endinterface

// File: rtl/ex_maddsub_unit_mul.sv
// Signed/unsigned MUL_W x MUL_W multiplier producing a 2*MUL_W product.
// Default build: purely combinational.
// With MADDSUB_MUL_PIPE_EN defined: two registered 16-bit-slice partial
// products are captured on i_load and summed combinationally afterwards.
module maddsub_mul
   import ex_maddsub_unit_pkg::*;
#(
   parameter int MUL_W = 32
)(
   input  logic               Clk,
   input  logic               Rst_n,
   input  logic               i_load,
   input  logic               i_signed,
   input  logic [MUL_W-1:0]   i_a,
   input  logic [MUL_W-1:0]   i_b,
   output logic [2*MUL_W-1:0] o_product
);

   localparam int ProdW = 2 * MUL_W;
   localparam int HalfW = MUL_W / 2;

   logic [ProdW-1:0] w_aWide;
   logic [ProdW-1:0] w_bWide;

   // Extending both operands to the full product width makes a plain
   // modulo-2^ProdW multiply correct for both signed and unsigned ops.
   assign w_aWide = {{MUL_W{i_signed & i_a[MUL_W-1]}}, i_a};
   assign w_bWide = {{MUL_W{i_signed & i_b[MUL_W-1]}}, i_b};

`ifdef MADDSUB_MUL_PIPE_EN
   logic [ProdW-1:0] w_aLo;
   logic [ProdW-1:0] w_aHi;
   logic [ProdW-1:0] r_ppLo;
   logic [ProdW-1:0] r_ppHi;

   // a = aLo + aHi * 2^HalfW exactly (modulo 2^ProdW), so the weighted sum
   // of the two partial products reproduces the full product.
   assign w_aLo = {{(ProdW - HalfW){1'b0}}, i_a[HalfW-1:0]};
   assign w_aHi = w_aWide >> HalfW;

   // First stage: register the low-slice and high-slice partial products.
   always_ff @(posedge Clk) begin
      if (Rst_n == RstEnable) begin
         r_ppLo <= '0;
         r_ppHi <= '0;
      end else if (i_load) begin
         r_ppLo <= w_aLo * w_bWide;
         r_ppHi <= w_aHi * w_bWide;
      end
   end

   assign o_product = r_ppLo + (r_ppHi << HalfW);
`else
   logic w_unusedPipe;

   assign w_unusedPipe = &{1'b0, Clk, Rst_n, i_load};
   assign o_product    = w_aWide * w_bWide;
`endif

endmodule

// File: rtl/ex_maddsub_unit.sv
// EX-stage multi-cycle multiply-accumulate unit for MADD/MADDU/MSUB/MSUBU.
// IDLE requests a stall and latches the product; ACC presents
// {hi,lo} +/- product (from the live forwarded HI/LO) with a write enable
// until the stall controller lets the instruction advance.
// Optional macro MADDSUB_MUL_PIPE_EN adds a MUL2 state for a two-stage
// multiplier (two stall cycles instead of one).
module ex_maddsub_unit
   import ex_maddsub_unit_pkg::*;
#(
   parameter int MUL_W = 32
)(
   input  logic             Clk,
   input  logic             Rst_n,
   ex_maddsub_unit_if.slave io_exBus
);

   maddState_e  r_state;
   maddState_e  w_nextState;
   DoubleRegBus r_product;

   logic        w_isFamily;
   logic        w_isSigned;
   logic        w_isSub;
   logic        w_exStop;
   logic        w_loadProduct;
   logic        w_mulLoad;
   logic [2*MUL_W-1:0] w_mulProduct;
   DoubleRegBus w_hiLoIn;
   DoubleRegBus w_accResult;

   logic        w_stallReq;
   logic        w_hiloWe;
   logic        w_busy;
   DoubleRegBus w_hiLoOut;
   logic        w_unusedStall;

   assign w_isFamily = isMaddFamily(io_exBus.aluop_i);
   assign w_isSigned = isMaddSigned(io_exBus.aluop_i);
   assign w_isSub    = isMaddSub(io_exBus.aluop_i);
   assign w_exStop   = (io_exBus.stall[StallExBit] == STOP);

   // Only the EX bit of the stall vector matters to this unit.
   assign w_unusedStall = &{1'b0, io_exBus.stall[5:4], io_exBus.stall[2:0]};

`ifdef MADDSUB_MUL_PIPE_EN
   // Partial products are captured on leaving IDLE, the summed product on leaving MUL2.
   assign w_mulLoad     = (r_state == MADD_IDLE) && w_isFamily;
   assign w_loadProduct = (r_state == MADD_MUL2) && w_isFamily;
`else
   assign w_mulLoad     = 1'b0;
   assign w_loadProduct = (r_state == MADD_IDLE) && w_isFamily;
`endif

   maddsub_mul #(
      .MUL_W     (MUL_W)
   ) u_mul (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .i_load    (w_mulLoad),
      .i_signed  (w_isSigned),
      .i_a       (io_exBus.reg1_i),
      .i_b       (io_exBus.reg2_i),
      .o_product (w_mulProduct)
   );

   // Accumulate against the live forwarded HI/LO so late forwarding is honoured.
   assign w_hiLoIn    = {io_exBus.hi_i, io_exBus.lo_i};
   assign w_accResult = w_isSub ? (w_hiLoIn - r_product) : (w_hiLoIn + r_product);

   // State register: synchronous active-low reset returns to IDLE.
   always_ff @(posedge Clk) begin
      if (Rst_n == RstEnable) begin
         r_state <= MADD_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Product register: loads once per instruction regardless of the EX stall bit.
   always_ff @(posedge Clk) begin
      if (Rst_n == RstEnable) begin
         r_product <= '0;
      end else if (w_loadProduct) begin
         r_product <= w_mulProduct;
      end
   end

   // Next-state logic: a non-family opcode outside IDLE is a flush back to IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         MADD_IDLE: begin
            if (w_isFamily) begin
`ifdef MADDSUB_MUL_PIPE_EN
               w_nextState = MADD_MUL2;
`else
               w_nextState = MADD_ACC;
`endif
            end
         end
`ifdef MADDSUB_MUL_PIPE_EN
         MADD_MUL2: begin
            w_nextState = w_isFamily ? MADD_ACC : MADD_IDLE;
         end
`endif
         MADD_ACC: begin
            if (!w_isFamily || !w_exStop) begin
               w_nextState = MADD_IDLE;
            end
         end
         default: begin
            w_nextState = MADD_IDLE;
         end
      endcase
   end

   // Output logic: everything is forced to zero while reset is asserted.
   always_comb begin
      w_stallReq = 1'b0;
      w_hiloWe   = 1'b0;
      w_busy     = 1'b0;
      w_hiLoOut  = {ZeroWord, ZeroWord};
      if (Rst_n != RstEnable) begin
         case (r_state)
            MADD_IDLE: begin
               w_stallReq = w_isFamily;
            end
`ifdef MADDSUB_MUL_PIPE_EN
            MADD_MUL2: begin
               w_busy     = 1'b1;
               w_stallReq = w_isFamily;
            end
`endif
            MADD_ACC: begin
               w_busy = 1'b1;
               if (w_isFamily) begin
                  w_hiloWe  = 1'b1;
                  w_hiLoOut = w_accResult;
               end
            end
            default: begin
               w_busy = 1'b0;
            end
         endcase
      end
   end

   assign io_exBus.stallreq_o = w_stallReq;
   assign io_exBus.hilo_we_o  = w_hiloWe;
   assign io_exBus.busy_o     = w_busy;
   assign io_exBus.hi_o       = w_hiLoOut[63:32];
   assign io_exBus.lo_o       = w_hiLoOut[31:0];

endmodule

// File: tb/tb_ex_maddsub_unit.sv
// Self-checking bench for ex_maddsub_unit: a driver issues directed and
// random MADD-family instructions, pushing each expected committed HI/LO
// into a queue; a monitor pops and compares on every committed write.
module tb_ex_maddsub_unit;

   localparam logic [7:0] OpMadd  = 8'b10100110;
   localparam logic [7:0] OpMaddu = 8'b10100111;
   localparam logic [7:0] OpMsub  = 8'b10101010;
   localparam logic [7:0] OpMsubu = 8'b10101011;
   localparam logic [7:0] OpNop   = 8'h00;
   localparam logic [5:0] StallStop   = 6'b001111;
   localparam logic [5:0] StallNoStop = 6'b000000;
`ifdef MADDSUB_MUL_PIPE_EN
   localparam int StallCycles = 2;
`else
   localparam int StallCycles = 1;
`endif

   logic Clk;
   logic Rst_n;
   int   checkCount;
   int   errorCount;
   logic [63:0] expQ[$];

   ex_maddsub_unit_if exIf();

   ex_maddsub_unit #(
      .MUL_W    (32)
   ) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .io_exBus (exIf)
   );

   // Free-running 10-time-unit clock.
   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic bit isFamilyRef(input logic [7:0] op);
      return (op == OpMadd) || (op == OpMaddu) || (op == OpMsub) || (op == OpMsubu);
   endfunction

   // Reference: 64-bit two's-complement arithmetic on the architectural values.
   function automatic logic [63:0] refMaddSub(input logic [7:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
      longint pa;
      longint pb;
      longint acc;
      if (op == OpMadd || op == OpMsub) begin
         pa = longint'($signed(a));
         pb = longint'($signed(b));
      end else begin
         pa = longint'(a);
         pb = longint'(b);
      end
      acc = longint'({hi, lo});
      if (op == OpMsub || op == OpMsubu) begin
         return 64'(acc - pa * pb);
      end
      return 64'(acc + pa * pb);
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every committed write (write enable with EX not stalled) must match the queue head.
   always @(negedge Clk) begin
      if (exIf.hilo_we_o === 1'b1 && exIf.stall[3] === 1'b0) begin
         if (expQ.size() == 0) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL unexpectedWrite: got %h:%h, expected no write at %0t",
                     exIf.hi_o, exIf.lo_o, $time);
         end else begin
            checkOutput("hiloResult", {exIf.hi_o, exIf.lo_o}, expQ.pop_front());
         end
      end
   end

   // Idle cycles with a random non-family opcode: everything must stay zero.
   task automatic applyIdle(input int n);
      for (int i = 0; i < n; i++) begin
         logic [7:0] op;
         op = 8'($urandom);
         if (isFamilyRef(op)) op = OpNop;
         exIf.aluop_i = op;
         exIf.reg1_i  = $urandom;
         exIf.reg2_i  = $urandom;
         exIf.stall   = StallNoStop;
         @(negedge Clk);
         checkOutput("idleStallReq", 64'(exIf.stallreq_o), 64'd0);
         checkOutput("idleWe", 64'(exIf.hilo_we_o), 64'd0);
         checkOutput("idleBusy", 64'(exIf.busy_o), 64'd0);
         checkOutput("idleHiLo", {exIf.hi_o, exIf.lo_o}, 64'd0);
         @(posedge Clk); #1;
      end
   endtask

   // Issue one instruction: stall cycles, optional held ACC cycles, optional
   // late HI forwarding, then a commit cycle whose result goes to the scoreboard.
   task automatic applyStimulus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] hi, input logic [31:0] lo, input int holdCycles,
                                input bit doFwd, input logic [31:0] fwdHi, input bit useConst,
                                input logic [63:0] constExp, output logic [63:0] result);
      logic [63:0] heldExp;
      logic [31:0] hiNow;
      exIf.aluop_i = op;
      exIf.reg1_i  = a;
      exIf.reg2_i  = b;
      exIf.hi_i    = hi;
      exIf.lo_i    = lo;
      exIf.stall   = StallStop;
      for (int k = 0; k < StallCycles; k++) begin
         @(negedge Clk);
         checkOutput("mulStallReq", 64'(exIf.stallreq_o), 64'd1);
         checkOutput("mulWe", 64'(exIf.hilo_we_o), 64'd0);
         checkOutput("mulBusy", 64'(exIf.busy_o), (k > 0) ? 64'd1 : 64'd0);
         @(posedge Clk); #1;
      end
      heldExp = refMaddSub(op, a, b, hi, lo);
      for (int h = 0; h < holdCycles; h++) begin
         exIf.stall = StallStop;
         @(negedge Clk);
         checkOutput("holdStallReq", 64'(exIf.stallreq_o), 64'd0);
         checkOutput("holdWe", 64'(exIf.hilo_we_o), 64'd1);
         checkOutput("holdBusy", 64'(exIf.busy_o), 64'd1);
         checkOutput("holdHiLo", {exIf.hi_o, exIf.lo_o}, heldExp);
         @(posedge Clk); #1;
      end
      hiNow = doFwd ? fwdHi : hi;
      exIf.hi_i = hiNow;
      result = useConst ? constExp : refMaddSub(op, a, b, hiNow, lo);
      exIf.stall = StallNoStop;
      expQ.push_back(result);
      @(negedge Clk);
      checkOutput("accStallReq", 64'(exIf.stallreq_o), 64'd0);
      @(posedge Clk); #1;
   endtask

   // Flush: opcode replaced by NOP while in ACC must suppress the write.
   task automatic applyFlush(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      exIf.aluop_i = op;
      exIf.reg1_i  = a;
      exIf.reg2_i  = b;
      exIf.stall   = StallStop;
      repeat (StallCycles) begin
         @(posedge Clk); #1;
      end
      exIf.aluop_i = OpNop;
      exIf.stall   = StallNoStop;
      @(negedge Clk);
      checkOutput("flushWe", 64'(exIf.hilo_we_o), 64'd0);
      checkOutput("flushHiLo", {exIf.hi_o, exIf.lo_o}, 64'd0);
      @(posedge Clk); #1;
      @(negedge Clk);
      checkOutput("flushIdleBusy", 64'(exIf.busy_o), 64'd0);
      @(posedge Clk); #1;
   endtask

   // Reset asserted while in ACC: outputs zero immediately and IDLE afterwards.
   task automatic applyMidReset(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      exIf.aluop_i = op;
      exIf.reg1_i  = a;
      exIf.reg2_i  = b;
      exIf.stall   = StallStop;
      repeat (StallCycles) begin
         @(posedge Clk); #1;
      end
      Rst_n      = 1'b0;
      exIf.stall = StallNoStop;
      @(negedge Clk);
      checkOutput("rstWe", 64'(exIf.hilo_we_o), 64'd0);
      checkOutput("rstStallReq", 64'(exIf.stallreq_o), 64'd0);
      checkOutput("rstHiLo", {exIf.hi_o, exIf.lo_o}, 64'd0);
      @(posedge Clk); #1;
      Rst_n        = 1'b1;
      exIf.aluop_i = OpNop;
      @(negedge Clk);
      checkOutput("rstIdleBusy", 64'(exIf.busy_o), 64'd0);
      checkOutput("rstIdleWe", 64'(exIf.hilo_we_o), 64'd0);
      @(posedge Clk); #1;
   endtask

   // Main stimulus sequence.
   initial begin
      logic [63:0] res;
      logic [63:0] prev;
      logic [7:0]  fam[4];
      logic [31:0] corners[6];
      checkCount = 0;
      errorCount = 0;
      fam     = '{OpMadd, OpMaddu, OpMsub, OpMsubu};
      corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 32'h0001_0000};

      Rst_n        = 1'b0;
      exIf.stall   = StallNoStop;
      exIf.aluop_i = OpMadd;
      exIf.reg1_i  = 32'd3;
      exIf.reg2_i  = 32'd4;
      exIf.hi_i    = 32'd0;
      exIf.lo_i    = 32'd0;
      repeat (2) @(posedge Clk);
      #1;
      @(negedge Clk);
      checkOutput("resetStallReq", 64'(exIf.stallreq_o), 64'd0);
      checkOutput("resetWe", 64'(exIf.hilo_we_o), 64'd0);
      checkOutput("resetBusy", 64'(exIf.busy_o), 64'd0);
      checkOutput("resetHiLo", {exIf.hi_o, exIf.lo_o}, 64'd0);
      @(posedge Clk); #1;
      Rst_n        = 1'b1;
      exIf.aluop_i = OpNop;
      applyIdle(2);

      applyStimulus(OpMadd, 32'd3, 32'd4, 32'd0, 32'd5, 0, 1'b0, 32'd0, 1'b1,
                    64'h0000_0000_0000_0011, res);
      applyStimulus(OpMsub, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b1,
                    64'h0000_0000_0000_0002, res);
      applyStimulus(OpMsubu, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b1,
                    64'hFFFF_FFFE_0000_0002, res);
      applyStimulus(OpMaddu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,
                    1'b0, 32'd0, 1'b1, 64'hFFFF_FFFE_0000_0000, res);
      applyIdle(1);
      applyStimulus(OpMadd, 32'd5, 32'd7, 32'd1, 32'd10, 3, 1'b1, 32'h0000_1234, 1'b1,
                    64'h0000_1234_0000_002D, res);
      applyIdle(1);
      applyStimulus(OpMadd, 32'd2, 32'd3, 32'd0, 32'd0, 0, 1'b0, 32'd0, 1'b1,
                    64'h0000_0000_0000_0006, prev);
      applyStimulus(OpMadd, 32'h10, 32'h10, prev[63:32], prev[31:0], 0, 1'b0, 32'd0, 1'b1,
                    64'h0000_0000_0000_0106, res);
      applyFlush(OpMadd, 32'd9, 32'd9);
      applyMidReset(OpMsub, 32'd7, 32'd8);

      prev = 64'd0;
      for (int i = 0; i < 40; i++) begin
         logic [7:0]  op;
         logic [31:0] a;
         logic [31:0] b;
         logic [31:0] hi;
         logic [31:0] lo;
         int          hold;
         bit          fwd;
         op = fam[$urandom_range(0, 3)];
         a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         if ($urandom_range(0, 1) == 0) begin
            hi = prev[63:32];
            lo = prev[31:0];
         end else begin
            hi = $urandom;
            lo = $urandom;
         end
         hold = $urandom_range(0, 2);
         fwd  = (hold > 0) && ($urandom_range(0, 2) == 0);
         applyStimulus(op, a, b, hi, lo, hold, fwd, $urandom, 1'b0, 64'd0, prev);
         if ($urandom_range(0, 2) == 0) applyIdle(1);
      end

      applyIdle(3);
      checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
